// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing defaults, monitor state encoding and CRC constants.
package vga_timing_pkg;
  localparam int unsigned H_VIS_DEF        = 640;
  localparam int unsigned H_SYNC_START_DEF = 656;
  localparam int unsigned H_SYNC_END_DEF   = 751;
  localparam int unsigned H_TOTAL_DEF      = 800;
  localparam int unsigned V_VIS_DEF        = 480;
  localparam int unsigned V_SYNC_START_DEF = 490;
  localparam int unsigned V_SYNC_END_DEF   = 491;
  localparam int unsigned V_TOTAL_DEF      = 525;

  typedef logic [1:0] mon_state_t;
  localparam mon_state_t ACQ  = 2'd0;
  localparam mon_state_t LINE = 2'd1;
  localparam mon_state_t LOCK = 2'd2;

  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [15:0] CRC_PRESET = 16'hFFFF;
endpackage

// File: rtl/crc16_step.sv
// One pixel step of CRC-16-CCITT: six data bits shifted in MSB first.
module crc16_step
  import vga_timing_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [5:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < 6; i++) begin
      if (crc_out[15] ^ data[5 - i])
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      else
        crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// TinyVGA receive-side monitor: locks to sync timing, recovers coordinates,
// flags sync/blanking faults and signs each complete frame with a CRC.
module vga_frame_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS        = H_VIS_DEF,
  parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_END   = H_SYNC_END_DEF,
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned V_VIS        = V_VIS_DEF,
  parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
  parameter int unsigned V_SYNC_END   = V_SYNC_END_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        locked,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic [5:0]  rgb,
  output logic        display_on,
  output logic [15:0] frame_crc,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        sync_err,
  output logic        blank_err
);

  localparam logic [9:0] HV  = 10'(H_VIS);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_END);
  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VV  = 10'(V_VIS);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VSE = 10'(V_SYNC_END);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);

  logic [7:0]  s1, s2;
  mon_state_t  state, state_d;
  logic [9:0]  h_q, v_q, cur_h, cur_v, h_nxt, v_nxt;
  logic        hs1, vs1, hs2, vs2, hs_edge, vs_edge;
  logic        trk, sync_bad, disp, crc_armed;
  logic [5:0]  rgb_s1;
  logic [15:0] crc_q, crc_base, crc_step;

  assign hs1     = s1[7] ^ SYNC_ACTIVE_LOW;
  assign vs1     = s1[3] ^ SYNC_ACTIVE_LOW;
  assign hs2     = s2[7] ^ SYNC_ACTIVE_LOW;
  assign vs2     = s2[3] ^ SYNC_ACTIVE_LOW;
  assign hs_edge = hs1 & ~hs2;
  assign vs_edge = vs1 & ~vs2;
  assign rgb_s1  = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};

  // h_q/v_q hold the coordinate of the sample currently in s1. The LINE->LOCK
  // sample is itself tracked (row V_SYNC_START) so locked rises with vpos.
  always_comb begin
    state_d = state;
    trk     = 1'b0;
    cur_h   = h_q;
    cur_v   = v_q;
    case (state)
      ACQ:  if (hs_edge) state_d = LINE;
      LINE: begin
        if (hs_edge && h_q != HSS) begin
          state_d = ACQ;
        end else if (vs_edge) begin
          state_d = (h_q == '0) ? LOCK : ACQ;
          trk     = (h_q == '0);
          cur_v   = VSS;
        end
      end
      LOCK:    trk = 1'b1;
      default: state_d = ACQ;
    endcase
    sync_bad = (hs1 != ((cur_h >= HSS) && (cur_h <= HSE))) ||
               (vs1 != ((cur_v >= VSS) && (cur_v <= VSE)));
    if (trk && sync_bad) state_d = ACQ;
    h_nxt    = (cur_h == HT1) ? '0 : cur_h + 10'd1;
    v_nxt    = (cur_v == VT1) ? '0 : cur_v + 10'd1;
    disp     = trk && (cur_h < HV) && (cur_v < VV);
    crc_base = (cur_h == '0 && cur_v == '0) ? CRC_PRESET : crc_q;
  end

  crc16_step u_crc16_step (
    .crc_in  (crc_base),
    .data    (rgb_s1),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      state       <= ACQ;
      h_q         <= '0;
      v_q         <= '0;
      crc_q       <= CRC_PRESET;
      crc_armed   <= 1'b0;
      locked      <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      rgb         <= '0;
      display_on  <= 1'b0;
      frame_crc   <= CRC_PRESET;
      frame_done  <= 1'b0;
      frame_count <= '0;
      sync_err    <= 1'b0;
      blank_err   <= 1'b0;
    end else begin
      s1         <= vga_in;
      s2         <= s1;
      state      <= state_d;
      locked     <= trk;
      hpos       <= cur_h;
      vpos       <= cur_v;
      rgb        <= rgb_s1;
      display_on <= disp;
      frame_done <= 1'b0;

      if (state == ACQ) begin
        if (hs_edge) h_q <= HSS + 10'd1;
      end else begin
        h_q <= h_nxt;
      end
      if (trk) v_q <= (cur_h == HT1) ? v_nxt : cur_v;

      if (disp) crc_q <= crc_step;
      if (trk && sync_bad) sync_err <= 1'b1;
      if (trk && !disp && rgb_s1 != '0) blank_err <= 1'b1;

      // A sync error wins over both arming and latching in the same cycle.
      if (!trk || sync_bad) begin
        crc_armed <= 1'b0;
      end else if (cur_h == '0 && cur_v == '0) begin
        crc_armed <= 1'b1;
      end else if (cur_h == '0 && cur_v == VV && crc_armed) begin
        crc_armed   <= 1'b0;
        frame_crc   <= crc_q;
        frame_done  <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a scaled-down 16x10 timing.
module tb_vga_frame_monitor;
  localparam int HV = 8, HSS = 10, HSE = 12, HT = 16;
  localparam int VV = 6, VSS = 7, VSE = 8, VT = 10;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'hFF;
  logic        locked, display_on, frame_done, sync_err, blank_err;
  logic [9:0]  hpos, vpos;
  logic [5:0]  rgb;
  logic [15:0] frame_crc;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  vga_frame_monitor #(
    .H_VIS(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_VIS(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .locked(locked),
    .hpos(hpos), .vpos(vpos), .rgb(rgb), .display_on(display_on),
    .frame_crc(frame_crc), .frame_done(frame_done), .frame_count(frame_count),
    .sync_err(sync_err), .blank_err(blank_err)
  );

  int n_vec = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // source generator state
  int sh = 0, sv = 0, mode = 0, short_row = -1;
  bit blank_inj = 1'b0;
  int d1h = 0, d1v = 0, d2h = 0, d2v = 0;
  logic [5:0] d1p = '0, d2p = '0;
  logic [15:0] model_crc = 16'hFFFF, model_done_crc = 16'hFFFF;
  // observation state
  int done_cnt = 0, coord_hits = 0, exp_fc = 0;
  bit done_now = 1'b0, chk_track = 1'b0, fault_watch = 1'b0, fault_next = 1'b0;
  logic [15:0] last_crc = '0;

  function automatic logic [5:0] pix_of(input int h, input int v);
    logic [5:0] p;
    if (h >= HV || v >= VV) return 6'h00;
    case (mode)
      1:       p = (h == 3 && v == 2) ? 6'h3F : 6'h00;
      2:       p = 6'(h * 3 + v * 5 + 1);
      3:       p = 6'(h * 3 + v * 5 + 1) ^ ((h == 5 && v == 4) ? 6'h01 : 6'h00);
      default: p = 6'h00;
    endcase
    return p;
  endfunction

  // Reference: align the 6 data bits under the CRC top, then divide.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c ^ {d, 10'b0};
    for (int k = 0; k < 6; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic step();
    logic [5:0] p;
    logic hs, vs;
    @(posedge clk);
    #1;
    done_now = 1'b0;
    if (frame_done) begin
      done_cnt++;
      last_crc = frame_crc;
      done_now = 1'b1;
      if (chk_track) begin
        check_val("done_crc", 32'(frame_crc), 32'(model_done_crc));
        check_val("done_vpos", 32'(vpos), 32'(VV));
        check_val("done_hpos", 32'(hpos), 32'd0);
      end
    end
    if (fault_next) begin
      check_val("lock_drop", 32'(locked), 32'd0);
      fault_next = 1'b0;
    end
    if (fault_watch && d2h == HSE && d2v == short_row) begin
      check_val("fault_locked", 32'(locked), 32'd1);
      check_val("fault_sync_err", 32'(sync_err), 32'd1);
      chk_track   = 1'b0;
      fault_watch = 1'b0;
      fault_next  = 1'b1;
    end
    if (chk_track) begin
      check_val("locked", 32'(locked), 32'd1);
      check_val("hpos", 32'(hpos), 32'(d2h));
      check_val("vpos", 32'(vpos), 32'(d2v));
      check_val("rgb", 32'(rgb), 32'(d2p));
      check_val("display_on", 32'(display_on), 32'(d2h < HV && d2v < VV));
    end
    if (locked && rgb == 6'h3F) coord_hits++;

    p = pix_of(sh, sv);
    if (blank_inj && sh == 13 && sv == 3) p = 6'h01;
    hs = (sh >= HSS && sh <= HSE);
    if (sv == short_row && sh == HSE) hs = 1'b0;
    vs = (sv >= VSS && sv <= VSE);
    vga_in = {~hs, p[0], p[2], p[4], ~vs, p[1], p[3], p[5]};
    if (sh == 0 && sv == 0) model_crc = 16'hFFFF;
    if (sh < HV && sv < VV) model_crc = crc_model(model_crc, p);
    if (sh == 0 && sv == VV) model_done_crc = model_crc;
    d2h = d1h; d2v = d1v; d2p = d1p;
    d1h = sh;  d1v = sv;  d1p = p;
    sh++;
    if (sh == HT) begin
      sh = 0;
      sv = (sv == VT - 1) ? 0 : sv + 1;
    end
  endtask

  task automatic goto_origin();
    while (!(sh == 0 && sv == 0)) step();
  endtask

  task automatic wait_locked(input string tag);
    for (int i = 0; i < 2 * FRAME && !locked; i++) step();
    check_val(tag, 32'(locked), 32'd1);
    check_val("lock_hpos", 32'(hpos), 32'd0);
    check_val("lock_vpos", 32'(vpos), 32'(VSS));
    chk_track = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      step();
      if (done_now) break;
    end
    check_val(tag, 32'(done_now), 32'd1);
    exp_fc++;
    check_val("frame_count", 32'(frame_count), 32'(exp_fc));
  endtask

  task automatic check_reset_vals();
    check_val("rst_locked", 32'(locked), 32'd0);
    check_val("rst_hpos", 32'(hpos), 32'd0);
    check_val("rst_vpos", 32'(vpos), 32'd0);
    check_val("rst_rgb", 32'(rgb), 32'd0);
    check_val("rst_display_on", 32'(display_on), 32'd0);
    check_val("rst_frame_crc", 32'(frame_crc), 32'hFFFF);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_frame_count", 32'(frame_count), 32'd0);
    check_val("rst_sync_err", 32'(sync_err), 32'd0);
    check_val("rst_blank_err", 32'(blank_err), 32'd0);
  endtask

  initial begin
    logic [15:0] m_a, crc_a;
    int c0;

    // reset and lock-on with black pixels
    repeat (4) step();
    check_reset_vals();
    rst_n = 1'b1;
    wait_locked("lock_on");
    check_val("lock_sync_err", 32'(sync_err), 32'd0);
    wait_done("first_done", 2 * FRAME);

    // coordinate recovery: single white pixel at (3,2)
    goto_origin();
    mode = 1;
    coord_hits = 0;
    repeat (FRAME) step();
    check_val("coord_hits", 32'(coord_hits), 32'd1);
    exp_fc++;
    check_val("coord_fc", 32'(frame_count), 32'(exp_fc));

    // signature stability and single-pixel sensitivity
    mode = 2;
    c0 = done_cnt;
    repeat (FRAME) step();
    crc_a = last_crc;
    m_a   = model_done_crc;
    check_val("sig_a_done", 32'(done_cnt), 32'(c0 + 1));
    check_val("sig_a", 32'(crc_a), 32'(m_a));
    repeat (FRAME) step();
    check_val("sig_b_stable", 32'(last_crc), 32'(m_a));
    mode = 3;
    repeat (FRAME) step();
    check_val("sig_flip_model", 32'(last_crc), 32'(model_done_crc));
    check_val("sig_flip_differs", 32'(last_crc != m_a), 32'd1);
    exp_fc += 3;
    check_val("sig_fc", 32'(frame_count), 32'(exp_fc));

    // sync fault: hsync pulse one column short on row 2
    mode = 2;
    short_row = 2;
    fault_watch = 1'b1;
    c0 = done_cnt;
    repeat (FRAME) step();
    short_row = -1;
    check_val("fault_no_done", 32'(done_cnt), 32'(c0));
    check_val("fault_sticky", 32'(sync_err), 32'd1);
    check_val("fault_relock", 32'(locked), 32'd1);
    chk_track = 1'b1;
    wait_done("fault_next_done", FRAME + 4);

    // blanking violation at column 13 of row 3
    goto_origin();
    check_val("blank_pre", 32'(blank_err), 32'd0);
    blank_inj = 1'b1;
    repeat (FRAME) step();
    blank_inj = 1'b0;
    check_val("blank_err", 32'(blank_err), 32'd1);
    check_val("blank_locked", 32'(locked), 32'd1);
    exp_fc++;
    check_val("blank_fc", 32'(frame_count), 32'(exp_fc));

    // asynchronous reset mid-frame, then reacquisition
    while (!(sh == 4 && sv == 3)) step();
    chk_track = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) step();
    rst_n = 1'b1;
    exp_fc = 0;
    wait_locked("reset_relock");
    wait_done("reset_first_done", 2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
